pwm_bridge_driver: RTL and testbench

//  Downstream stage of the PID controller: converts the signed 16-bit controller output into

---
 rtl/pwm_bridge_driver_if.sv | 22 ++
 rtl/pwm_bridge_driver.sv | 144 ++++++++++++++
 tb/tb_pwm_bridge_driver.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_bridge_driver_if.sv
// Command and drive signals of the H-bridge PWM driver.
// Master side issues commands, slave side produces the leg drives.
interface pwm_bridge_driver_if;
    logic               enable;
    logic signed [15:0] pwm_cmd;
    logic               cmd_valid;
    logic               pwm_a;
    logic               pwm_b;
    logic               dir;
    logic               period_start;
    logic        [15:0] duty_applied;

    modport master (
        output enable, pwm_cmd, cmd_valid,
        input  pwm_a, pwm_b, dir, period_start, duty_applied
    );

    modport slave (
        input  enable, pwm_cmd, cmd_valid,
        output pwm_a, pwm_b, dir, period_start, duty_applied
    );
endinterface

// File: rtl/pwm_bridge_driver.sv
// Signed command to edge-aligned H-bridge PWM with dead time on reversal.
// Define PWM_SLEW_LIMIT_EN to limit the duty change per PWM period.
module pwm_bridge_driver #(
    parameter int unsigned PERIOD_CYCLES   = 2500,
    parameter int unsigned DEADTIME_CYCLES = 50,
    parameter int unsigned MAX_DUTY        = 2400,
    parameter int unsigned SLEW_STEP       = 64
) (
    input logic                clock,
    input logic                reset,
    pwm_bridge_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} state_t;

    localparam logic [15:0] LAST = 16'(PERIOD_CYCLES - 1);
    localparam logic [15:0] DT   = 16'(DEADTIME_CYCLES);
    localparam logic [16:0] DMAX = 17'(MAX_DUTY);

    state_t             state;
    logic        [15:0] cnt;
    logic        [15:0] duty;
    logic signed [15:0] shadow;
    logic               dir_q;
    logic               pwm_a_q;
    logic               pwm_b_q;
    logic               pstart_q;

    logic               wrap;
    logic        [15:0] cnt_n;
    logic        [16:0] mag;
    logic        [15:0] target;
    logic               req_dir;
    logic        [15:0] toward;
    logic        [15:0] entry;

    // Counter advance and decode of the shadowed command
    always_comb begin
        wrap   = (state == IDLE) || (cnt == LAST);
        cnt_n  = wrap ? 16'd0 : cnt + 16'd1;
        mag    = shadow[15] ? 17'd0 - {shadow[15], shadow}
                            : {1'b0, shadow};
        target = (mag > DMAX) ? DMAX[15:0] : mag[15:0];
        if (shadow[15])
            req_dir = 1'b1;
        else if (shadow == 16'sd0)
            req_dir = dir_q;
        else
            req_dir = 1'b0;
    end

`ifdef PWM_SLEW_LIMIT_EN
    localparam logic [15:0] STEP = 16'(SLEW_STEP);
    logic [15:0] down;

    // Duty moves by at most STEP at each period boundary
    always_comb begin
        if (target > duty)
            toward = (target - duty > STEP) ? duty + STEP : target;
        else
            toward = (duty - target > STEP) ? duty - STEP : target;
        entry = (target > STEP) ? STEP : target;
        down  = (duty > STEP) ? duty - STEP : 16'd0;
    end
`else
    // Duty jumps straight to the clamped target
    always_comb begin
        toward = target;
        entry  = target;
    end
`endif

    // Period counter, direction FSM and registered leg drive
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            shadow   <= 16'sd0;
            duty     <= 16'd0;
            dir_q    <= 1'b0;
            pwm_a_q  <= 1'b0;
            pwm_b_q  <= 1'b0;
            pstart_q <= 1'b0;
        end else begin
            if (bus.cmd_valid)
                shadow <= bus.pwm_cmd;
            if (!bus.enable) begin
                state    <= IDLE;
                cnt      <= 16'd0;
                duty     <= 16'd0;
                dir_q    <= 1'b0;
                pwm_a_q  <= 1'b0;
                pwm_b_q  <= 1'b0;
                pstart_q <= 1'b0;
            end else begin
                cnt      <= cnt_n;
                pstart_q <= wrap;
                pwm_a_q  <= 1'b0;
                pwm_b_q  <= 1'b0;
                unique case (state)
                    IDLE, FWD, REV: begin
                        if (!wrap) begin
                            pwm_a_q <= !dir_q && (cnt_n < duty);
                            pwm_b_q <= dir_q && (cnt_n < duty);
                        end else if (req_dir != dir_q) begin
`ifdef PWM_SLEW_LIMIT_EN
                            if (duty != 16'd0) begin
                                duty    <= down;
                                pwm_a_q <= !dir_q && (down != 16'd0);
                                pwm_b_q <= dir_q && (down != 16'd0);
                            end else begin
                                state <= DEAD;
                            end
`else
                            state <= DEAD;
                            duty  <= 16'd0;
`endif
                        end else begin
                            state   <= dir_q ? REV : FWD;
                            duty    <= toward;
                            pwm_a_q <= !dir_q && (toward != 16'd0);
                            pwm_b_q <= dir_q && (toward != 16'd0);
                        end
                    end
                    DEAD: begin
                        if (cnt_n >= DT) begin
                            state   <= req_dir ? REV : FWD;
                            dir_q   <= req_dir;
                            duty    <= entry;
                            pwm_a_q <= !req_dir && (cnt_n < entry);
                            pwm_b_q <= req_dir && (cnt_n < entry);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pwm_a        = pwm_a_q;
    assign bus.pwm_b        = pwm_b_q;
    assign bus.dir          = dir_q;
    assign bus.period_start = pstart_q;
    assign bus.duty_applied = duty;
endmodule

// File: tb/tb_pwm_bridge_driver.sv
// Bench for pwm_bridge_driver: directed commands, a period-level
// reference model compared every cycle, and literal duty/pulse counts.
module tb_pwm_bridge_driver;
    localparam int P    = 2500;
    localparam int D    = 50;
    localparam int MAXD = 2400;
    localparam int STEP = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;

    pwm_bridge_driver_if bus ();

    pwm_bridge_driver #(
        .PERIOD_CYCLES  (P),
        .DEADTIME_CYCLES(D),
        .MAX_DUTY       (MAXD),
        .SLEW_STEP      (STEP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int shown    = 0;

    // Reference model state: position in period, direction, duty, dead window
    int m_cnt, m_shadow, m_duty;
    bit m_run, m_dir, m_dead, m_a, m_b, m_ps, m_ok;

    function automatic int approach(int cur, int tgt);
`ifdef PWM_SLEW_LIMIT_EN
        if (tgt > cur + STEP) return cur + STEP;
        if (tgt < cur - STEP) return cur - STEP;
`endif
        if (cur == tgt) return cur;
        return tgt;
    endfunction

    // Model advances on the same edge the design samples its inputs
    always @(posedge clock) begin : model
        int sh, mag;
        bit want, on;
        sh = m_shadow;
        if (!reset) begin
            m_ok = 1; m_run = 0; m_cnt = 0; m_shadow = 0;
            m_duty = 0; m_dir = 0; m_dead = 0; m_ps = 0;
        end else begin
            if (bus.cmd_valid) m_shadow = int'(bus.pwm_cmd);
            if (!bus.enable) begin
                m_run = 0; m_cnt = 0; m_duty = 0;
                m_dir = 0; m_dead = 0; m_ps = 0;
            end else begin
                m_cnt = m_run ? (m_cnt + 1) % P : 0;
                m_run = 1;
                m_ps  = (m_cnt == 0);
                mag   = (sh < 0) ? -sh : sh;
                if (mag > MAXD) mag = MAXD;
                want  = (sh < 0) ? 1'b1 : ((sh > 0) ? 1'b0 : m_dir);
                if (m_cnt == 0) begin
                    if (want != m_dir) begin
`ifdef PWM_SLEW_LIMIT_EN
                        if (m_duty > 0) m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
                        else m_dead = 1;
`else
                        m_dead = 1;
                        m_duty = 0;
`endif
                    end else begin
                        m_duty = approach(m_duty, mag);
                    end
                end else if (m_dead && m_cnt >= D) begin
                    m_dead = 0;
                    m_dir  = want;
                    m_duty = approach(0, mag);
                end
            end
        end
        on  = m_run && !m_dead && (m_cnt < m_duty);
        m_a = on && !m_dir;
        m_b = on && m_dir;
    end

    // Per-cycle comparison against the model, plus the leg exclusion rule
    always @(negedge clock) begin
        if (m_ok) begin
            checks++;
            if (bus.pwm_a !== m_a || bus.pwm_b !== m_b || bus.dir !== m_dir ||
                bus.period_start !== m_ps || bus.duty_applied !== 16'(m_duty)) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL model t=%0t got a=%b b=%b dir=%b ps=%b duty=%0d expected a=%b b=%b dir=%b ps=%b duty=%0d",
                             $time, bus.pwm_a, bus.pwm_b, bus.dir, bus.period_start, bus.duty_applied,
                             m_a, m_b, m_dir, m_ps, m_duty);
                end
            end
            checks++;
            if (bus.pwm_a === 1'b1 && bus.pwm_b === 1'b1) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL legs_exclusive t=%0t got a=1 b=1 expected not both high", $time);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic strobe(input int v);
        bus.pwm_cmd   = 16'(v);
        bus.cmd_valid = 1'b1;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic sync_wrap();
        int n;
        n = 0;
        @(negedge clock);
        while (bus.period_start !== 1'b1 && n < 3 * P) begin
            @(negedge clock);
            n++;
        end
        check("wrap_seen", int'(bus.period_start === 1'b1), 1);
    endtask

    // Counts leg activity over one whole period; ends on its last cycle
    task automatic measure(output int na, output int nb,
                           output int fo, output int de);
        sync_wrap();
        na = 0; nb = 0; fo = -1; de = 0;
        for (int i = 0; i < P; i++) begin
            if (bus.pwm_a === 1'b1) na++;
            if (bus.pwm_b === 1'b1) nb++;
            if (fo < 0 && (bus.pwm_a === 1'b1 || bus.pwm_b === 1'b1)) fo = i;
            de = int'(bus.duty_applied);
            if (i < P - 1) @(negedge clock);
        end
    endtask

    initial begin
        int na, nb, fo, de;
        bus.enable    = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.pwm_cmd   = 16'sd0;
        reset         = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_a", int'(bus.pwm_a), 0);
        check("reset_b", int'(bus.pwm_b), 0);
        check("reset_duty", int'(bus.duty_applied), 0);
        check("reset_ps", int'(bus.period_start), 0);

        reset      = 1'b1;
        bus.enable = 1'b1;
        strobe(1000);
`ifdef PWM_SLEW_LIMIT_EN
        for (int k = 1; k <= 16; k++) begin
            measure(na, nb, fo, de);
            check($sformatf("slew_duty_%0d", k), de, (64 * k > 1000) ? 1000 : 64 * k);
            check($sformatf("slew_a_%0d", k), na, de);
        end
`else
        measure(na, nb, fo, de);
        check("fwd1000_a", na, 1000);
        check("fwd1000_b", nb, 0);
        check("fwd1000_duty", de, 1000);
        check("fwd1000_first", fo, 0);
`endif

        repeat (300) @(negedge clock);
        check("midpulse_a", int'(bus.pwm_a), 1);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("rst_hold_ab", int'(bus.pwm_a) + int'(bus.pwm_b), 0);
            check("rst_hold_duty", int'(bus.duty_applied), 0);
        end
        reset = 1'b1;
        @(negedge clock);
        check("rst_after_ab", int'(bus.pwm_a) + int'(bus.pwm_b), 0);
        check("rst_after_duty", int'(bus.duty_applied), 0);

`ifndef PWM_SLEW_LIMIT_EN
        strobe(-32768);
        measure(na, nb, fo, de);
        check("min_rev_b", nb, 2350);
        check("min_rev_a", na, 0);
        check("min_rev_first", fo, D);
        check("min_rev_duty", de, 2400);
        measure(na, nb, fo, de);
        check("min_full_b", nb, 2400);
        check("min_dir", int'(bus.dir), 1);

        strobe(1000);
        measure(na, nb, fo, de);
        check("rev2fwd_a", na, 950);
        check("rev2fwd_b", nb, 0);
        check("rev2fwd_first", fo, D);
        strobe(-500);
        measure(na, nb, fo, de);
        check("fwd2rev_b", nb, 450);
        check("fwd2rev_a", na, 0);
        check("fwd2rev_first", fo, D);
        check("fwd2rev_duty", de, 500);
        measure(na, nb, fo, de);
        check("rev500_b", nb, 500);
        check("rev500_first", fo, 0);

        repeat (10) @(negedge clock);
        strobe(100);
        strobe(200);
        strobe(300);
        measure(na, nb, fo, de);
        check("last_wins_duty", de, 300);
        check("last_wins_a", na, 250);
        measure(na, nb, fo, de);
        check("last_wins_full", na, 300);
        strobe(0);
        measure(na, nb, fo, de);
        check("zero_ab", na + nb, 0);
        check("zero_duty", de, 0);
        check("zero_dir", int'(bus.dir), 0);

        strobe(700);
        measure(na, nb, fo, de);
        check("fwd700_a", na, 700);
        bus.enable = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("dis_a", int'(bus.pwm_a), 0);
            check("dis_duty", int'(bus.duty_applied), 0);
        end
        bus.enable = 1'b1;
        @(negedge clock);
        check("reen_ps", int'(bus.period_start), 1);
        check("reen_a", int'(bus.pwm_a), 1);
        check("reen_duty", int'(bus.duty_applied), 700);
`endif
        repeat (20) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
